// File: rtl/ysyx_23060332_idu_pipe.sv
// ---------------------------------------------------------------------------
// ysyx_23060332_idu_pipe
// Registered RV32I decode stage sitting between IFU and EXU.
//   - Accepts one instruction per cycle over in_valid/in_ready.
//   - Reads the register file combinationally (rf_raddr* -> rf_rdata*).
//   - Builds ALU operands, jump base/offset and store data, flags illegal and
//     EBREAK, and holds the result in a single output register.
//   - A per-register busy scoreboard stalls RAW/WAW hazards against
//     instructions still in flight; writeback clears the bits.
//   - flush squashes the held entry and blocks acceptance for that cycle.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        IFU handshake; in_inst, in_pc payload
//   rf_raddr1/2, rf_rdata1/2 register file read port (same-cycle data)
//   out_valid/out_ready      EXU handshake
//   out_op1/op2              ALU operands
//   out_op1_jump/op2_jump    jump/branch base and offset
//   out_rs2_data             rs2 value (store data)
//   out_wen/out_waddr        destination write enable / register
//   out_inst                 raw instruction
//   out_illegal/out_ebreak   decode flags
//   flush                    squash held entry
//   wb_valid/wb_addr         writeback retiring a destination register
// ---------------------------------------------------------------------------
module ysyx_23060332_idu_pipe #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_inst,
   input  logic [XLEN-1:0]   in_pc,
   output logic [REG_AW-1:0] rf_raddr1,
   output logic [REG_AW-1:0] rf_raddr2,
   input  logic [XLEN-1:0]   rf_rdata1,
   input  logic [XLEN-1:0]   rf_rdata2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_op1,
   output logic [XLEN-1:0]   out_op2,
   output logic [XLEN-1:0]   out_op1_jump,
   output logic [XLEN-1:0]   out_op2_jump,
   output logic [XLEN-1:0]   out_rs2_data,
   output logic              out_wen,
   output logic [REG_AW-1:0] out_waddr,
   output logic [31:0]       out_inst,
   output logic              out_illegal,
   output logic              out_ebreak,
   input  logic              flush,
   input  logic              wb_valid,
   input  logic [REG_AW-1:0] wb_addr
);

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
   localparam int NREG = 2 ** REG_AW;

   // Instruction fields
   logic [6:0]        opcode, funct7;
   logic [2:0]        funct3;
   logic [REG_AW-1:0] rd, rs1, rs2;
   assign opcode = in_inst[6:0];
   assign funct3 = in_inst[14:12];
   assign funct7 = in_inst[31:25];
   assign rd     = REG_AW'(in_inst[11:7]);
   assign rs1    = REG_AW'(in_inst[19:15]);
   assign rs2    = REG_AW'(in_inst[24:20]);

   // Immediates, sign-extended to XLEN
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   assign imm_i = XLEN'($signed(in_inst[31:20]));
   assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
   assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
   assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
   assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));

   // On RV64 the shift amount takes one more bit out of the funct7 field.
   logic shamt_hi_zero, shamt_hi_sra;
   assign shamt_hi_zero = (XLEN == 64) ? (in_inst[31:26] == 6'b000000) : (funct7 == 7'b0000000);
   assign shamt_hi_sra  = (XLEN == 64) ? (in_inst[31:26] == 6'b010000) : (funct7 == 7'b0100000);

   // Control decode: legality and which register fields are really used.
   logic legal, rs1_used, rs2_used, writes_rd;
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
      legal     = 1'b0;
      rs1_used  = 1'b0;
      rs2_used  = 1'b0;
      writes_rd = 1'b0;
      case (opcode)
         OPC_OP_IMM: begin
            rs1_used  = 1'b1;
            writes_rd = 1'b1;
            if (funct3 == 3'b001)      legal = shamt_hi_zero;
            else if (funct3 == 3'b101) legal = shamt_hi_zero | shamt_hi_sra;
            else                       legal = 1'b1;
         end
         OPC_OP: begin
            rs1_used  = 1'b1;
            rs2_used  = 1'b1;
            writes_rd = 1'b1;
            // Only ADD/SUB and SRL/SRA have an alternate funct7 encoding.
            legal = (funct7 == 7'b0000000) |
                    ((funct7 == 7'b0100000) & ((funct3 == 3'b000) | (funct3 == 3'b101)));
         end
         OPC_LOAD: begin
            rs1_used  = 1'b1;
            writes_rd = 1'b1;
            legal     = (funct3 != 3'b011) & (funct3[2:1] != 2'b11);  // LB/LH/LW/LBU/LHU
         end
         OPC_STORE: begin
            rs1_used = 1'b1;
            rs2_used = 1'b1;
            legal    = ~funct3[2] & (funct3[1:0] != 2'b11);           // SB/SH/SW
         end
         OPC_BRANCH: begin
            rs1_used = 1'b1;
            rs2_used = 1'b1;
            legal    = (funct3[2:1] != 2'b01);                          // 010/011 reserved
         end
         OPC_LUI, OPC_AUIPC, OPC_JAL: begin
            writes_rd = 1'b1;
            legal     = 1'b1;
         end
         OPC_JALR: begin
            rs1_used  = 1'b1;
            writes_rd = 1'b1;
            legal     = (funct3 == 3'b000);
         end
         OPC_SYSTEM: legal = (in_inst == INST_ECALL) | (in_inst == INST_EBREAK);
         default: ;
      endcase
      if (!legal) begin
         rs1_used  = 1'b0;
         rs2_used  = 1'b0;
         writes_rd = 1'b0;
      end
   end

   // Unused fields read x0, so the scoreboard lookup below needs no extra gating.
   assign rf_raddr1 = rs1_used ? rs1 : '0;
   assign rf_raddr2 = rs2_used ? rs2 : '0;

   // Operand generation; kept apart from the control decode because it
   // depends on rf_rdata, which itself depends on the read addresses.
   logic [XLEN-1:0] d_op1, d_op2, d_j1, d_j2;
   always_comb begin
      d_op1 = '0;
      d_op2 = '0;
      d_j1  = '0;
      d_j2  = '0;
      if (legal) begin
         case (opcode)
            OPC_OP_IMM, OPC_LOAD: begin d_op1 = rf_rdata1; d_op2 = imm_i;     end
            OPC_STORE:            begin d_op1 = rf_rdata1; d_op2 = imm_s;     end
            OPC_OP:               begin d_op1 = rf_rdata1; d_op2 = rf_rdata2; end
            OPC_BRANCH: begin
               d_op1 = rf_rdata1;
               d_op2 = rf_rdata2;
               d_j1  = in_pc;
               d_j2  = imm_b;
            end
            OPC_LUI:   d_op1 = imm_u;
            OPC_AUIPC: begin d_op1 = in_pc; d_op2 = imm_u; end
            OPC_JAL: begin
               d_op1 = in_pc;
               d_op2 = XLEN'(4);
               d_j1  = in_pc;
               d_j2  = imm_j;
            end
            OPC_JALR: begin
               d_op1 = in_pc;
               d_op2 = XLEN'(4);
               d_j1  = rf_rdata1;
               d_j2  = imm_i;
            end
            default: ;
         endcase
      end
   end

   // Handshake and hazard detection (registered busy bits only).
   logic [NREG-1:0] busy, busy_next;
   logic            wen_dec, hazard, accept, squash;
   assign wen_dec  = writes_rd & (rd != '0);
   assign hazard   = in_valid & (busy[rf_raddr1] | busy[rf_raddr2] | (wen_dec & busy[rd]));
   assign in_ready = ~flush & ~hazard & (~out_valid | out_ready);
   assign accept   = in_valid & in_ready;
   // A flushed entry that the EXU takes in the same cycle counts as consumed.
   assign squash   = flush & out_valid & ~out_ready;

   always_comb begin
      busy_next = busy;
      if (wb_valid)          busy_next[wb_addr]   = 1'b0;
      if (squash && out_wen) busy_next[out_waddr] = 1'b0;
      if (accept && wen_dec) busy_next[rd]        = 1'b1;  // set beats a same-cycle clear
      busy_next[0] = 1'b0;
   end

   // NOTE: the scoreboard and the output register are ordinary flops (no RAM), so they are reset explicitly; a reset leaves no stale entry or busy bit.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      if (rst) busy <= '0;
      else     busy <= busy_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_op1      <= '0;
         out_op2      <= '0;
         out_op1_jump <= '0;
         out_op2_jump <= '0;
         out_rs2_data <= '0;
         out_wen      <= 1'b0;
         out_waddr    <= '0;
         out_inst     <= '0;
         out_illegal  <= 1'b0;
         out_ebreak   <= 1'b0;
      end else if (accept) begin
         out_valid    <= 1'b1;
         out_op1      <= d_op1;
         out_op2      <= d_op2;
         out_op1_jump <= d_j1;
         out_op2_jump <= d_j2;
         out_rs2_data <= rf_rdata2;
         out_wen      <= wen_dec;
         out_waddr    <= rd;
         out_inst     <= in_inst;
         out_illegal  <= ~legal;
         out_ebreak   <= (in_inst == INST_EBREAK);
      end else if (flush || out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ysyx_23060332_idu_pipe.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060332_idu_pipe
// Scoreboard bench for the decode stage. The driver applies one stimulus
// vector per cycle, predicts in_ready/out_valid from a behavioural model of
// the busy table, and pushes the expected decode of every accepted
// instruction into a queue. An independent monitor pops that queue whenever
// the DUT hands an entry to the EXU (or a flush squashes it) and compares.
// ---------------------------------------------------------------------------
module tb_ysyx_23060332_idu_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [31:0] in_inst, in_pc;
   logic [4:0]  rf_raddr1, rf_raddr2;
   logic [31:0] rf_rdata1, rf_rdata2;
   logic        out_valid, out_ready;
   logic [31:0] out_op1, out_op2, out_op1_jump, out_op2_jump, out_rs2_data;
   logic        out_wen;
   logic [4:0]  out_waddr;
   logic [31:0] out_inst;
   logic        out_illegal, out_ebreak;
   logic        flush, wb_valid;
   logic [4:0]  wb_addr;

   always #5 clk = ~clk;

   // Register file contents seen by the stage (x0 reads as zero).
   logic [31:0] regs [32];
   assign rf_rdata1 = regs[rf_raddr1];
   assign rf_rdata2 = regs[rf_raddr2];

   ysyx_23060332_idu_pipe #(.XLEN(32), .REG_AW(5)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_op1(out_op1), .out_op2(out_op2), .out_op1_jump(out_op1_jump), .out_op2_jump(out_op2_jump),
      .out_rs2_data(out_rs2_data), .out_wen(out_wen), .out_waddr(out_waddr), .out_inst(out_inst),
      .out_illegal(out_illegal), .out_ebreak(out_ebreak),
      .flush(flush), .wb_valid(wb_valid), .wb_addr(wb_addr)
   );

   typedef struct packed {
      logic        ill, ebr, wen, r1u, r2u, chk_data, chk_jump;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] op1, op2, j1, j2, rs2d, inst;
   } exp_t;

   int   n_vec = 0;
   int   n_bad = 0;
   exp_t q[$];

   // Model state: busy table and the held output entry.
   logic       busy_m [32];
   logic       m_ov;
   logic       m_held_wen;
   logic [4:0] m_held_rd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference decode written straight from the ISA rules with integer arithmetic.
   function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
      exp_t e;
      int   f3, f7, opc;
      int   imm_i, imm_s, imm_b, imm_j, imm_u;
      logic ok, wr;
      e     = '0;
      ok    = 1'b0;
      wr    = 1'b0;
      f3    = int'(inst[14:12]);
      f7    = int'(inst[31:25]);
      opc   = int'(inst[6:0]);
      imm_i = int'($signed(inst)) >>> 20;
      imm_s = ((int'($signed(inst)) >>> 25) * 32) + int'(inst[11:7]);
      imm_b = (inst[31] ? -4096 : 0) + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
      imm_j = (inst[31] ? -1048576 : 0) + int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
      imm_u = int'(inst & 32'hFFFF_F000);
      e.inst = inst;
      e.rd   = inst[11:7];
      e.rs1  = inst[19:15];
      e.rs2  = inst[24:20];
      case (opc)
         'h13: begin
            ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 32) : 1'b1;
            e.r1u = 1'b1; wr = 1'b1; e.op1 = regs[e.rs1]; e.op2 = imm_i;
         end
         'h33: begin
            ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
            e.r1u = 1'b1; e.r2u = 1'b1; wr = 1'b1; e.op1 = regs[e.rs1]; e.op2 = regs[e.rs2];
         end
         'h03: begin
            ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
            e.r1u = 1'b1; wr = 1'b1; e.op1 = regs[e.rs1]; e.op2 = imm_i;
         end
         'h23: begin
            ok = (f3 <= 2);
            e.r1u = 1'b1; e.r2u = 1'b1; e.op1 = regs[e.rs1]; e.op2 = imm_s;
         end
         'h63: begin
            ok = (f3 != 2 && f3 != 3);
            e.r1u = 1'b1; e.r2u = 1'b1; e.op1 = regs[e.rs1]; e.op2 = regs[e.rs2];
            e.j1 = pc; e.j2 = imm_b; e.chk_jump = 1'b1;
         end
         'h37: begin ok = 1'b1; wr = 1'b1; e.op1 = imm_u; end
         'h17: begin ok = 1'b1; wr = 1'b1; e.op1 = pc; e.op2 = imm_u; end
         'h6f: begin
            ok = 1'b1; wr = 1'b1; e.op1 = pc; e.op2 = 4; e.j1 = pc; e.j2 = imm_j; e.chk_jump = 1'b1;
         end
         'h67: begin
            ok = (f3 == 0); e.r1u = 1'b1; wr = 1'b1;
            e.op1 = pc; e.op2 = 4; e.j1 = regs[e.rs1]; e.j2 = imm_i; e.chk_jump = 1'b1;
         end
         'h73: ok = (inst == 32'h0000_0073 || inst == 32'h0010_0073);
         default: ok = 1'b0;
      endcase
      if (!ok) begin
         e.r1u = 1'b0; e.r2u = 1'b0; wr = 1'b0; e.chk_jump = 1'b0;
      end
      e.ill      = !ok;
      e.ebr      = (inst == 32'h0010_0073);
      e.wen      = ok && wr && (e.rd != 0);
      e.rs2d     = e.r2u ? regs[e.rs2] : 32'h0;
      e.chk_data = ok && (opc != 'h73);
      return e;
   endfunction

   // One clock of stimulus: drive at the falling edge, check the combinational
   // handshake, and advance the model to what the next rising edge produces.
   task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic ordy, input logic fl, input logic wbv, input logic [4:0] wba);
      exp_t e;
      logic haz, rdy, acc;
      @(negedge clk);
      in_valid  = v;
      in_inst   = inst;
      in_pc     = pc;
      out_ready = ordy;
      flush     = fl;
      wb_valid  = wbv;
      wb_addr   = wba;
      #1;
      e   = ref_decode(inst, pc);
      haz = v && ((e.r1u && busy_m[e.rs1]) || (e.r2u && busy_m[e.rs2]) || (e.wen && busy_m[e.rd]));
      rdy = !fl && !haz && (!m_ov || ordy);
      check("in_ready", {31'b0, in_ready}, {31'b0, rdy});
      check("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
      acc = v && rdy;
      if (acc) q.push_back(e);
      if (wbv && wba != 0) busy_m[wba] = 1'b0;
      if (fl && m_ov && !ordy && m_held_wen) busy_m[m_held_rd] = 1'b0;
      if (acc && e.wen) busy_m[e.rd] = 1'b1;
      if (acc) begin
         m_ov       = 1'b1;
         m_held_wen = e.wen;
         m_held_rd  = e.rd;
      end else if (fl || ordy) begin
         m_ov = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; wb_valid = 1'b0;
      q.delete();
      for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
      m_ov = 1'b0; m_held_wen = 1'b0; m_held_rd = '0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", {31'b0, out_valid}, 32'h0);
      check("rst_out_wen", {31'b0, out_wen}, 32'h0);
      check("rst_out_illegal", {31'b0, out_illegal}, 32'h0);
      check("rst_out_op1", out_op1, 32'h0);
      check("rst_out_inst", out_inst, 32'h0);
      check("rst_in_ready", {31'b0, in_ready}, 32'h1);
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] r   = $urandom();
      logic [4:0]  rd  = 5'($urandom_range(0, 7));
      logic [4:0]  rs1 = 5'($urandom_range(0, 7));
      logic [4:0]  rs2 = 5'($urandom_range(0, 7));
      logic [2:0]  f3  = r[14:12];
      logic [6:0]  f7  = ($urandom_range(0, 3) == 0) ? r[31:25] : (r[30] ? 7'h20 : 7'h00);
      case ($urandom_range(0, 11))
         0:  return {f7, rs2, rs1, f3, rd, 7'h13};
         1:  return {f7, rs2, rs1, f3, rd, 7'h33};
         2:  return {r[31:20], rs1, f3, rd, 7'h03};
         3:  return {r[31:25], rs2, rs1, f3, r[11:7], 7'h23};
         4:  return {r[31:25], rs2, rs1, f3, r[11:7], 7'h63};
         5:  return {r[31:12], rd, 7'h37};
         6:  return {r[31:12], rd, 7'h17};
         7:  return {r[31:12], rd, 7'h6f};
         8:  return {r[31:20], rs1, (r[0] ? 3'b000 : f3), rd, 7'h67};
         9:  return r[5] ? 32'h0010_0073 : 32'h0000_0073;
         10: return r;
         default: return 32'h0;
      endcase
   endfunction

   // Monitor: compares every entry the DUT hands over, discards squashed ones.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (!rst && out_valid && (out_ready || flush)) begin
            if (q.size() == 0) begin
               check("entry_expected", q.size(), 1);
            end else begin
               e = q.pop_front();
               if (out_ready) begin
                  check("inst", out_inst, e.inst);
                  check("illegal", {31'b0, out_illegal}, {31'b0, e.ill});
                  check("ebreak", {31'b0, out_ebreak}, {31'b0, e.ebr});
                  check("wen", {31'b0, out_wen}, {31'b0, e.wen});
                  if (e.wen) check("waddr", {27'b0, out_waddr}, {27'b0, e.rd});
                  if (e.chk_data) begin
                     check("op1", out_op1, e.op1);
                     check("op2", out_op2, e.op2);
                     check("rs2_data", out_rs2_data, e.rs2d);
                  end
                  if (e.chk_jump) begin
                     check("op1_jump", out_op1_jump, e.j1);
                     check("op2_jump", out_op2_jump, e.j2);
                  end
               end
            end
         end
      end
   end

   initial begin : driver
      logic [31:0] pc;
      rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0;
      out_ready = 1'b0; flush = 1'b0; wb_valid = 1'b0; wb_addr = '0;
      regs[0] = 32'h0;
      for (int i = 1; i < 32; i++) regs[i] = $urandom();
      do_reset();

      // addi x1,x0,5
      step(1'b1, 32'h0050_0093, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 5'd0);
      // add x2,x1,x1 stalls on x1, retire x1, then it is accepted
      step(1'b1, 32'h0010_8133, 32'h8000_0004, 1'b1, 1'b0, 1'b0, 5'd0);
      step(1'b1, 32'h0010_8133, 32'h8000_0004, 1'b1, 1'b0, 1'b1, 5'd1);
      step(1'b1, 32'h0010_8133, 32'h8000_0004, 1'b1, 1'b0, 1'b0, 5'd0);
      // EXU back-pressure for three cycles, then addi x3,x0,10 loads
      for (int i = 0; i < 3; i++)
         step(1'b1, 32'h00a0_0193, 32'h8000_0008, 1'b0, 1'b0, 1'b0, 5'd0);
      step(1'b1, 32'h00a0_0193, 32'h8000_0008, 1'b1, 1'b0, 1'b0, 5'd0);
      // beq x0,x0,-8 at 0x80000010
      step(1'b1, 32'hFE00_0CE3, 32'h8000_0010, 1'b1, 1'b0, 1'b0, 5'd0);
      // illegal, ebreak, ecall, all-zero
      step(1'b1, 32'hFFFF_FFFF, 32'h8000_0014, 1'b1, 1'b0, 1'b0, 5'd0);
      step(1'b1, 32'h0010_0073, 32'h8000_0018, 1'b1, 1'b0, 1'b0, 5'd0);
      step(1'b1, 32'h0000_0073, 32'h8000_001c, 1'b1, 1'b0, 1'b0, 5'd0);
      step(1'b1, 32'h0000_0000, 32'h8000_0020, 1'b1, 1'b0, 1'b0, 5'd0);
      // lw x5 held then flushed; add x6,x5,x5 goes straight in
      step(1'b1, 32'h0000_2283, 32'h8000_0024, 1'b1, 1'b0, 1'b0, 5'd0);
      step(1'b0, 32'h0000_0000, 32'h8000_0028, 1'b0, 1'b1, 1'b0, 5'd0);
      step(1'b1, 32'h0052_8333, 32'h8000_0028, 1'b1, 1'b0, 1'b0, 5'd0);
      step(1'b0, 32'h0000_0000, 32'h8000_002c, 1'b1, 1'b0, 1'b0, 5'd0);

      // Randomised traffic with back-pressure, flushes, writebacks and a mid-run reset.
      for (int i = 0; i < 1500; i++) begin
         if (i == 700) do_reset();
         pc = $urandom() & 32'hFFFF_FFFC;
         step($urandom_range(0, 9) < 8, rand_inst(), pc, $urandom_range(0, 3) != 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)));
      end

      for (int i = 0; i < 4; i++)
         step(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 5'd0);
      check("queue_drained", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
